// File: rtl/gpr_pkg.sv
// Shared GPR writeback types: register index, data width and the writeback request payload.
package gpr_pkg;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREG      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned STARVE_W  = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic            valid;
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits: set at issue, cleared on the GPR write edge, plus the issue busy lookup.
module gpr_scoreboard
    import gpr_pkg::*;
(
    input  logic     WrClk,
    input  logic     rst,
    input  logic     setEn,
    input  reg_idx_t setIdx,
    input  logic     clrEn,
    input  reg_idx_t clrIdx,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    input  reg_idx_t rd,
    input  logic     wenChk,
    output logic     busy,
    output logic     pendAny
);
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pendingNxt;

    // Clear is applied first so a same-edge set of the same register wins.
    always_comb begin
        pendingNxt = pending;
        if (clrEn && clrIdx != '0) begin
            pendingNxt[clrIdx] = 1'b0;
        end
        if (setEn && setIdx != '0) begin
            pendingNxt[setIdx] = 1'b1;
        end
        pendingNxt[0] = 1'b0;
    end

    always_ff @(posedge WrClk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pendingNxt;
        end
    end

    assign busy    = pending[rs1] || pending[rs2] || (wenChk && pending[rd]);
    assign pendAny = |pending;
endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port master: arbitrates EXU/LSU writebacks (LSU first, EXU anti-starvation),
// registers the winner onto RegWr/Rw/busW and gates issue on the pending scoreboard.
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 WrClk,
    input  logic                 rst,
    input  logic                 exu_valid,
    output logic                 exu_ready,
    input  logic [REG_IDX_W-1:0] exu_rd,
    input  logic [XLEN-1:0]      exu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [REG_IDX_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]      lsu_data,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic                 iss_wen,
    input  logic [REG_IDX_W-1:0] iss_rd,
    input  logic [REG_IDX_W-1:0] iss_rs1,
    input  logic [REG_IDX_W-1:0] iss_rs2,
    output logic                 RegWr,
    output logic [REG_IDX_W-1:0] Rw,
    output logic [XLEN-1:0]      busW,
    output logic                 pend_any
);
    wb_req_t             exuReq;
    wb_req_t             lsuReq;
    wb_req_t             winReq;
    logic [STARVE_W-1:0] starveCnt;
    logic                forceExu;
    logic                exuGrant;
    logic                lsuGrant;
    logic                issBusy;

    assign exuReq = '{valid: exu_valid, rd: exu_rd, data: exu_data};
    assign lsuReq = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};

    // Single grant per cycle; nothing is accepted while in reset.
    always_comb begin
        forceExu = starveCnt >= STARVE_W'(STARVE_LIMIT);
        lsuGrant = !rst && lsuReq.valid && !forceExu;
        exuGrant = !rst && exuReq.valid && (!lsuReq.valid || forceExu);
        winReq   = '0;
        if (lsuGrant) begin
            winReq = lsuReq;
        end else if (exuGrant) begin
            winReq = exuReq;
        end
    end

    assign exu_ready = exuGrant;
    assign lsu_ready = lsuGrant;

    always_ff @(posedge WrClk) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (exu_valid && !exuGrant) begin
            starveCnt <= (starveCnt == '1) ? starveCnt : starveCnt + STARVE_W'(1);
        end else begin
            starveCnt <= '0;
        end
    end

    // A granted rd=0 request is consumed without a GPR write; Rw/busW keep their last values.
    always_ff @(posedge WrClk) begin
        if (rst) begin
            RegWr <= 1'b0;
            Rw    <= '0;
            busW  <= '0;
        end else if (winReq.valid && winReq.rd != '0) begin
            RegWr <= 1'b1;
            Rw    <= winReq.rd;
            busW  <= winReq.data;
        end else begin
            RegWr <= 1'b0;
        end
    end

    gpr_scoreboard u_scoreboard (
        .WrClk   (WrClk),
        .rst     (rst),
        .setEn   (iss_valid && iss_ready && iss_wen),
        .setIdx  (iss_rd),
        .clrEn   (RegWr),
        .clrIdx  (Rw),
        .rs1     (iss_rs1),
        .rs2     (iss_rs2),
        .rd      (iss_rd),
        .wenChk  (iss_wen),
        .busy    (issBusy),
        .pendAny (pend_any)
    );

    assign iss_ready = !issBusy;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: vector table, directed corner sequences and randomized traffic vs a reference model.
module tb_gpr_wb_arbiter;
    localparam int unsigned LIMIT = 4;

    logic        WrClk;
    logic        rst;
    logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
    logic [4:0]  exu_rd, lsu_rd;
    logic [31:0] exu_data, lsu_data;
    logic        iss_valid, iss_ready, iss_wen;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic        RegWr;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic        pend_any;

    gpr_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .WrClk(WrClk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_wen(iss_wen),
        .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .RegWr(RegWr), .Rw(Rw), .busW(busW), .pend_any(pend_any)
    );

    initial WrClk = 1'b0;
    always #5 WrClk = ~WrClk;

    int checks = 0;
    int failures = 0;
    int orphans = 0;

    // Reference model state: which registers await a writeback, how long EXU has waited,
    // and what the GPR write port should show.
    bit          mPend[32];
    int          mRef;
    bit          mWr, mKnown;
    logic [4:0]  mRw;
    logic [31:0] mBus;
    bit          mEw, mLw;
    logic        obsEr, obsLr, obsIss;

    typedef struct {
        logic ev; logic [4:0] erd; logic [31:0] ed;
        logic lv; logic [4:0] lrd; logic [31:0] ld;
        logic xEr; logic xLr; logic xWr; logic chkRw; logic [4:0] xRw; logic [31:0] xBus;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit modelPendAny();
        bit r = 1'b0;
        for (int i = 0; i < 32; i++) r |= mPend[i];
        return r;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
        mRef = 0; mWr = 1'b0; mRw = '0; mBus = '0; mKnown = 1'b1;
    endtask

    task automatic idle();
        exu_valid = 0; exu_rd = 0; exu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        iss_valid = 0; iss_wen = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    endtask

    // One clock: check handshakes mid-cycle, advance the model at the edge, check registered outputs.
    task automatic step();
        bit          fe, iR, grant;
        logic [4:0]  wrd;
        logic [31:0] wd;
        #1;
        obsEr = exu_ready; obsLr = lsu_ready; obsIss = iss_ready;
        fe  = (mRef >= int'(LIMIT));
        mLw = !rst && lsu_valid && !fe;
        mEw = !rst && exu_valid && (!lsu_valid || fe);
        iR  = !(mPend[iss_rs1] || mPend[iss_rs2] || (iss_wen && mPend[iss_rd]));
        chk("m_exu_ready", 32'(obsEr), 32'(mEw));
        chk("m_lsu_ready", 32'(obsLr), 32'(mLw));
        chk("m_iss_ready", 32'(obsIss), 32'(iR));
        if (!rst && exu_valid && lsu_valid) chk("one_grant", 32'(obsEr ^ obsLr), 32'd1);
        @(posedge WrClk);
        if (rst) begin
            modelReset();
        end else begin
            grant = mEw || mLw;
            wrd   = mLw ? lsu_rd : exu_rd;
            wd    = mLw ? lsu_data : exu_data;
            if (grant && wrd != 0 && !mPend[wrd]) orphans++;
            if (mWr) mPend[mRw] = 1'b0;
            if (iss_valid && iR && iss_wen && iss_rd != 0) mPend[iss_rd] = 1'b1;
            mRef = (exu_valid && !mEw) ? ((mRef < 15) ? mRef + 1 : 15) : 0;
            if (grant && wrd != 0) begin
                mWr = 1'b1; mRw = wrd; mBus = wd; mKnown = 1'b1;
            end else begin
                mWr = 1'b0;
                if (grant) mKnown = 1'b0;
            end
        end
        #1;
        chk("m_RegWr", 32'(RegWr), 32'(mWr));
        if (mKnown) begin
            chk("m_Rw", 32'(Rw), 32'(mRw));
            chk("m_busW", busW, mBus);
        end
        chk("m_pend_any", 32'(pend_any), 32'(modelPendAny()));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        modelReset();
        @(posedge WrClk); #1;
        @(posedge WrClk); #1;
        chk("rst_RegWr", 32'(RegWr), 32'd0);
        chk("rst_Rw", 32'(Rw), 32'd0);
        chk("rst_busW", busW, 32'd0);
        chk("rst_pend_any", 32'(pend_any), 32'd0);
        chk("rst_exu_ready", 32'(exu_ready), 32'd0);
        rst = 1'b0;

        // Single-cycle arbitration vectors applied back to back.
        tbl[0] = '{1, 5'd5, 32'h12345678, 0, 5'd0, 32'h0,        1, 0, 1, 1, 5'd5,  32'h12345678};
        tbl[1] = '{1, 5'd4, 32'h00005555, 1, 5'd3, 32'hAAAA0000, 0, 1, 1, 1, 5'd3,  32'hAAAA0000};
        tbl[2] = '{1, 5'd4, 32'h00005555, 0, 5'd0, 32'h0,        1, 0, 1, 1, 5'd4,  32'h00005555};
        tbl[3] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 0, 1, 5'd4,  32'h00005555};
        tbl[4] = '{1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0,        1, 0, 0, 0, 5'd0,  32'h0};
        tbl[5] = '{0, 5'd0, 32'h0,        1, 5'd31, 32'hDEADBEEF, 0, 1, 1, 1, 5'd31, 32'hDEADBEEF};
        tbl[6] = '{0, 5'd0, 32'h0,        1, 5'd0, 32'h01010101, 0, 1, 0, 0, 5'd0,  32'h0};
        for (int i = 0; i < 7; i++) begin
            idle();
            exu_valid = tbl[i].ev; exu_rd = tbl[i].erd; exu_data = tbl[i].ed;
            lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
            step();
            chk($sformatf("v%0d_exu_ready", i), 32'(obsEr), 32'(tbl[i].xEr));
            chk($sformatf("v%0d_lsu_ready", i), 32'(obsLr), 32'(tbl[i].xLr));
            chk($sformatf("v%0d_RegWr", i), 32'(RegWr), 32'(tbl[i].xWr));
            if (tbl[i].chkRw) begin
                chk($sformatf("v%0d_Rw", i), 32'(Rw), 32'(tbl[i].xRw));
                chk($sformatf("v%0d_busW", i), busW, tbl[i].xBus);
            end
            chk($sformatf("v%0d_pend_any", i), 32'(pend_any), 32'd0);
        end

        // Starvation: EXU refused four cycles, forced on the fifth, then LSU resumes.
        idle();
        for (int i = 0; i < 10; i++) begin
            lsu_valid = 1; lsu_rd = 5'd9;  lsu_data = 32'(i);
            exu_valid = 1; exu_rd = 5'd10; exu_data = 32'h000000E0;
            step();
            chk($sformatf("starve%0d_exu_ready", i), 32'(obsEr), 32'(i % 5 == 4));
            chk($sformatf("starve%0d_lsu_ready", i), 32'(obsLr), 32'(i % 5 != 4));
            chk($sformatf("starve%0d_Rw", i), 32'(Rw), (i % 5 == 4) ? 32'd10 : 32'd9);
        end

        // Scoreboard hazards on r7, then a same-edge set/clear on r8.
        idle(); rst = 1; step(); rst = 0;
        iss_valid = 1; iss_wen = 1; iss_rd = 5'd7; step();
        chk("sb_issue7_ready", 32'(obsIss), 32'd1);
        chk("sb_issue7_pend", 32'(pend_any), 32'd1);
        idle(); iss_valid = 1; iss_rs1 = 5'd7; step();
        chk("sb_raw_block", 32'(obsIss), 32'd0);
        idle(); iss_valid = 1; iss_wen = 1; iss_rd = 5'd7; step();
        chk("sb_waw_block", 32'(obsIss), 32'd0);
        idle(); iss_valid = 1; iss_wen = 1; iss_rd = 5'd0; step();
        chk("sb_rd0_free", 32'(obsIss), 32'd1);
        chk("sb_rd0_pend", 32'(pend_any), 32'd1);
        idle(); iss_valid = 1; iss_rs1 = 5'd7; exu_valid = 1; exu_rd = 5'd7; exu_data = 32'h77; step();
        chk("sb_wb_ready", 32'(obsEr), 32'd1);
        chk("sb_wb_block", 32'(obsIss), 32'd0);
        chk("sb_wb_RegWr", 32'(RegWr), 32'd1);
        chk("sb_wb_Rw", 32'(Rw), 32'd7);
        idle(); iss_valid = 1; iss_rs1 = 5'd7; step();
        chk("sb_wedge_block", 32'(obsIss), 32'd0);
        chk("sb_cleared", 32'(pend_any), 32'd0);
        idle(); iss_valid = 1; iss_rs1 = 5'd7; step();
        chk("sb_after_ready", 32'(obsIss), 32'd1);
        idle(); exu_valid = 1; exu_rd = 5'd8; exu_data = 32'h88; step();
        idle(); iss_valid = 1; iss_wen = 1; iss_rd = 5'd8; step();
        chk("sb_setwins_ready", 32'(obsIss), 32'd1);
        chk("sb_setwins_pend", 32'(pend_any), 32'd1);
        idle(); iss_rs2 = 5'd8; step();
        chk("sb_novalid_block", 32'(obsIss), 32'd0);

        // Reset while a write sits in the output register.
        idle(); exu_valid = 1; exu_rd = 5'd12; exu_data = 32'h1234; iss_valid = 1; iss_wen = 1; iss_rd = 5'd13;
        step();
        chk("rmf_grant_Rw", 32'(Rw), 32'd12);
        idle(); rst = 1; exu_valid = 1; exu_rd = 5'd14; lsu_valid = 1; lsu_rd = 5'd15;
        step();
        chk("rmf_exu_ready", 32'(obsEr), 32'd0);
        chk("rmf_lsu_ready", 32'(obsLr), 32'd0);
        chk("rmf_RegWr", 32'(RegWr), 32'd0);
        chk("rmf_Rw", 32'(Rw), 32'd0);
        chk("rmf_busW", busW, 32'd0);
        chk("rmf_pend_any", 32'(pend_any), 32'd0);
        rst = 0; idle();

        // Randomized traffic; a refused producer keeps its request stable until accepted.
        for (int n = 0; n < 2000; n++) begin
            if (rst || !exu_valid || mEw) begin
                exu_valid = ($urandom_range(0, 2) != 0);
                exu_rd    = 5'($urandom_range(0, 7));
                exu_data  = $urandom;
            end
            if (rst || !lsu_valid || mLw) begin
                lsu_valid = ($urandom_range(0, 2) == 0);
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 1) != 0);
            iss_wen   = ($urandom_range(0, 3) != 0);
            iss_rd    = 5'($urandom_range(0, 7));
            iss_rs1   = 5'($urandom_range(0, 7));
            iss_rs2   = 5'($urandom_range(0, 7));
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("note: %0d writebacks targeted a register with no pending writer", orphans);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
